sha256_msg_padder: RTL and testbench

Byte-stream front end of the SHA256 core: sits between the 8-bit `load_enable`/`input_complete` loading interface and the compression engine. It packs incoming message bytes big-endian into 32-bit words and appends the FIPS 180-4 padding. Padding is the 0x80 marker, zero fill, and the 64-bit big-endian bit length. The result is a stream of 16-word blocks with valid/ready handshake and block/message framing flags.

---
 rtl/sha256_msg_padder_if.sv | 25 ++
 rtl/sha256_msg_padder.sv | 166 ++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_padder_if.sv
// Byte-load and word-stream signals of the SHA256 message padder.
// master = byte source / word consumer side, slave = the padder itself.
interface sha256_msg_padder_if;
   logic        load_enable;
   logic        input_complete;
   logic [7:0]  input_data;
   logic        load_ready;
   logic        busy;
   logic        word_valid;
   logic        word_ready;
   logic [31:0] word_data;
   logic [3:0]  word_index;
   logic        block_last;
   logic        msg_last;

   modport master (
      output load_enable, input_complete, input_data, word_ready,
      input  load_ready, busy, word_valid, word_data, word_index, block_last, msg_last
   );

   modport slave (
      input  load_enable, input_complete, input_data, word_ready,
      output load_ready, busy, word_valid, word_data, word_index, block_last, msg_last
   );
endinterface

// File: rtl/sha256_msg_padder.sv
// Packs message bytes big-endian into 32-bit words and appends SHA256 padding
// (0x80 marker, zero fill, 64-bit bit length) as a stream of 16-word blocks.
module sha256_msg_padder #(
   parameter int unsigned CNT_W = 32
) (
   input logic              clock,
   input logic              reset,
   sha256_msg_padder_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StLoad, StPad, StZero, StLenHi, StLenLo} state_e;

   state_e             state_q, state_d;
   logic [23:0]        pack_q, pack_d;
   logic [1:0]         pack_cnt_q, pack_cnt_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic               word_valid_q, word_valid_d;
   logic [31:0]        word_data_q, word_data_d;
   logic [3:0]         word_index_q, word_index_d;
   logic               block_last_q, block_last_d;
   logic               msg_last_q, msg_last_d;

   logic               loading, load_ready, accept, handshake, out_free;
   logic [3:0]         next_idx;
   logic [63:0]        len64;
   logic [31:0]        pad_word;
   logic               emit, emit_last;
   logic [31:0]        emit_data;

   assign loading    = (state_q == StIdle) || (state_q == StLoad);
   assign load_ready = loading && !((pack_cnt_q == 2'd3) && word_valid_q);
   assign accept     = bus.load_enable && load_ready;
   assign handshake  = word_valid_q && bus.word_ready;
   assign out_free   = !word_valid_q || bus.word_ready;
   // Index of the word that would be loaded into the output register this cycle.
   assign next_idx   = word_index_q + (handshake ? 4'd1 : 4'd0);

   always_comb begin
      len64 = '0;
      len64[CNT_W-1:0] = len_q;
   end

   // Held bytes sit in the low end of pack_q, oldest byte highest.
   always_comb begin
      pad_word = 32'h8000_0000;
      unique case (pack_cnt_q)
         2'd0: pad_word = 32'h8000_0000;
         2'd1: pad_word = {pack_q[7:0], 24'h80_0000};
         2'd2: pad_word = {pack_q[15:0], 16'h8000};
         2'd3: pad_word = {pack_q[23:0], 8'h80};
         default: pad_word = 32'h8000_0000;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pack_d       = pack_q;
      pack_cnt_d   = pack_cnt_q;
      len_d        = len_q;
      word_valid_d = word_valid_q && !handshake;
      word_data_d  = word_data_q;
      word_index_d = next_idx;
      block_last_d = block_last_q;
      msg_last_d   = msg_last_q;
      emit         = 1'b0;
      emit_data    = '0;
      emit_last    = 1'b0;

      unique case (state_q)
         StIdle, StLoad: begin
            if (accept) begin
               len_d   = len_q + CNT_W'(8);
               state_d = StLoad;
               if (pack_cnt_q == 2'd3) begin
                  emit       = 1'b1;
                  emit_data  = {pack_q, bus.input_data};
                  pack_cnt_d = 2'd0;
               end else begin
                  pack_d     = {pack_q[15:0], bus.input_data};
                  pack_cnt_d = pack_cnt_q + 2'd1;
               end
            end
            if (bus.input_complete) state_d = StPad;
         end
         StPad: begin
            if (out_free) begin
               emit       = 1'b1;
               emit_data  = pad_word;
               pack_d     = '0;
               pack_cnt_d = 2'd0;
               state_d    = (next_idx == 4'd13) ? StLenHi : StZero;
            end
         end
         StZero: begin
            if (out_free) begin
               emit = 1'b1;
               if (next_idx == 4'd13) state_d = StLenHi;
            end
         end
         StLenHi: begin
            if (out_free) begin
               emit      = 1'b1;
               emit_data = len64[63:32];
               state_d   = StLenLo;
            end
         end
         StLenLo: begin
            // msg_last_q marks that the final word is already queued.
            if (msg_last_q) begin
               if (handshake) begin
                  state_d      = StIdle;
                  len_d        = '0;
                  word_index_d = 4'd0;
                  block_last_d = 1'b0;
                  msg_last_d   = 1'b0;
               end
            end else if (out_free) begin
               emit      = 1'b1;
               emit_data = len64[31:0];
               emit_last = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (emit) begin
         word_valid_d = 1'b1;
         word_data_d  = emit_data;
         block_last_d = (next_idx == 4'd15);
         msg_last_d   = emit_last;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         pack_q       <= '0;
         pack_cnt_q   <= 2'd0;
         len_q        <= '0;
         word_valid_q <= 1'b0;
         word_data_q  <= '0;
         word_index_q <= 4'd0;
         block_last_q <= 1'b0;
         msg_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pack_q       <= pack_d;
         pack_cnt_q   <= pack_cnt_d;
         len_q        <= len_d;
         word_valid_q <= word_valid_d;
         word_data_q  <= word_data_d;
         word_index_q <= word_index_d;
         block_last_q <= block_last_d;
         msg_last_q   <= msg_last_d;
      end
   end

   assign bus.load_ready = load_ready;
   assign bus.busy       = !loading;
   assign bus.word_valid = word_valid_q;
   assign bus.word_data  = word_data_q;
   assign bus.word_index = word_index_q;
   assign bus.block_last = block_last_q;
   assign bus.msg_last   = msg_last_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder against a byte-level padding model.
module tb_sha256_msg_padder;

   logic clock;
   logic reset;
   sha256_msg_padder_if bus();

   sha256_msg_padder #(.CNT_W(32)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   int checks   = 0;
   int failures = 0;
   logic [7:0]  msg_q[$];
   logic [31:0] exp_q[$];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit bit length.
   function automatic void build_exp();
      logic [7:0]  b[$];
      logic [63:0] bits;
      b = msg_q;
      bits = 64'(msg_q.size()) * 64'd8;
      b.push_back(8'h80);
      while ((b.size() % 64) != 56) b.push_back(8'h00);
      for (int i = 7; i >= 0; i--) b.push_back(bits[8*i +: 8]);
      exp_q.delete();
      for (int i = 0; i < b.size(); i += 4) exp_q.push_back({b[i], b[i+1], b[i+2], b[i+3]});
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_load_ready"}, 64'(bus.load_ready), 64'd1);
      check_val({tag, "_busy"},       64'(bus.busy),       64'd0);
      check_val({tag, "_word_valid"}, 64'(bus.word_valid), 64'd0);
      check_val({tag, "_word_data"},  64'(bus.word_data),  64'd0);
      check_val({tag, "_word_index"}, 64'(bus.word_index), 64'd0);
      check_val({tag, "_block_last"}, 64'(bus.block_last), 64'd0);
      check_val({tag, "_msg_last"},   64'(bus.msg_last),   64'd0);
   endtask

   // Called at posedge+1; drives msg_q and checks every emitted word.
   task automatic run_msg(input int ready_pct, input int le_pct, input bit cwl);
      int          n, sent, widx, nexp, cycles;
      bit          completed, done, stall;
      logic [31:0] stall_data;
      build_exp();
      n = msg_q.size();
      nexp = exp_q.size();
      sent = 0; widx = 0; cycles = 0;
      completed = 0; done = 0; stall = 0; stall_data = '0;
      while (!done && cycles < 4000) begin
         bus.load_enable    = 1'b0;
         bus.input_complete = 1'b0;
         if (!completed) begin
            if (sent < n && $urandom_range(0, 99) < le_pct) begin
               bus.load_enable = 1'b1;
               bus.input_data  = msg_q[sent];
               if (cwl && sent == n - 1 && bus.load_ready) bus.input_complete = 1'b1;
            end else if (sent == n) begin
               bus.input_complete = 1'b1;
            end
         end
         bus.word_ready = ($urandom_range(0, 99) < ready_pct);
         @(negedge clock);
         if (stall) begin
            check_val("stall_valid", 64'(bus.word_valid), 64'd1);
            check_val("stall_data",  64'(bus.word_data),  64'(stall_data));
         end
         if (!completed) begin
            check_val("busy_load", 64'(bus.busy), 64'd0);
            check_val("load_ready", 64'(bus.load_ready),
                      64'(!((sent % 4 == 3) && bus.word_valid)));
         end else begin
            check_val("busy_pad", 64'(bus.busy), 64'd1);
            check_val("load_ready_pad", 64'(bus.load_ready), 64'd0);
         end
         if (bus.load_enable && bus.load_ready) sent++;
         if (bus.input_complete) completed = 1;
         if (bus.word_valid && bus.word_ready) begin
            if (widx < nexp) begin
               check_val("word_data",  64'(bus.word_data),  64'(exp_q[widx]));
               check_val("word_index", 64'(bus.word_index), 64'(widx % 16));
               check_val("block_last", 64'(bus.block_last), 64'(widx % 16 == 15));
               check_val("msg_last",   64'(bus.msg_last),   64'(widx == nexp - 1));
            end else begin
               check_val("extra_word", 64'(widx), 64'(nexp - 1));
            end
            widx++;
            if (widx == nexp) done = 1;
         end
         stall = bus.word_valid && !bus.word_ready;
         stall_data = bus.word_data;
         @(posedge clock);
         #1;
         cycles++;
      end
      if (!done) check_val("timeout_words", 64'(widx), 64'(nexp));
      check_val("bytes_consumed", 64'(sent), 64'(n));
      bus.load_enable    = 1'b0;
      bus.input_complete = 1'b0;
      bus.word_ready     = 1'b0;
      check_val("idle_load_ready", 64'(bus.load_ready), 64'd1);
      check_val("idle_busy",       64'(bus.busy),       64'd0);
      check_val("idle_valid",      64'(bus.word_valid), 64'd0);
      check_val("idle_index",      64'(bus.word_index), 64'd0);
   endtask

   task automatic set_goirish();
      msg_q = '{8'h67, 8'h6F, 8'h69, 8'h72, 8'h69, 8'h73, 8'h68, 8'h0A};
   endtask

   initial begin
      bus.load_enable    = 1'b0;
      bus.input_complete = 1'b0;
      bus.input_data     = 8'h00;
      bus.word_ready     = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(posedge clock);
      #1;

      set_goirish();
      run_msg(100, 100, 0);

      msg_q.delete();
      run_msg(100, 100, 0);

      msg_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      run_msg(100, 100, 1);

      msg_q.delete();
      for (int i = 0; i < 56; i++) msg_q.push_back(8'hAA);
      run_msg(100, 100, 0);

      msg_q.delete();
      for (int i = 0; i < 40; i++) msg_q.push_back(8'($urandom));
      run_msg(25, 100, 0);

      // Mid-message reset after 6 bytes.
      bus.word_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.load_enable = 1'b1;
         bus.input_data  = 8'(i + 1);
         @(posedge clock);
         #1;
      end
      bus.load_enable = 1'b0;
      bus.word_ready  = 1'b0;
      reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      set_goirish();
      run_msg(100, 100, 0);

      for (int t = 0; t < 8; t++) begin
         int len;
         len = $urandom_range(0, 150);
         msg_q.delete();
         for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
         run_msg($urandom_range(20, 100), $urandom_range(30, 100), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
